prio_enc_pipe: RTL and testbench

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready handshake on both sides. Each accepted request vector is encoded into the index of the winning bit plus an "any request" flag, and presented one cycle later in an output register that holds under backpressure. It serves interrupt/request-select paths where the fixed 4-input combinational encoder is too narrow. An optional round-robin mode rotates priority between requesters.

---
 rtl/prio_enc_pipe.sv | 85 ++++++++
 tb/tb_prio_enc_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: registered N-to-log2(N) priority encoder with valid/ready handshake on both sides.
// Define PRIO_ENC_RR_EN to compile in round-robin priority; otherwise the highest set index wins.
module prio_enc_pipe #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_any
);
    logic         accept;
    logic         enc_any;
    logic [W-1:0] enc_idx;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_any_q, out_any_d;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_any   = out_any_q;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] cand;

    // Walk from the farthest slot back to ptr so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        enc_any = |req;
        enc_idx = '0;
        cand    = '0;
        for (int s = N - 1; s >= 0; s--) begin
            cand = W'((int'(ptr_q) + N - s) % N);
            if (req[cand]) enc_idx = cand;
        end
    end

    // The winner drops to lowest priority: ptr moves to the slot just below it, wrapping at 0.
    always_comb begin
        ptr_d = (accept && enc_any) ? ((enc_idx == '0) ? W'(N - 1) : enc_idx - W'(1)) : ptr_q;
    end

    // Pointer register; N-1 at reset makes the first grant match fixed priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= W'(N - 1);
        else        ptr_q <= ptr_d;
    end
`else
    // Fixed priority: scan upward so the highest set index is assigned last and wins.
    always_comb begin
        enc_any = |req;
        enc_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) enc_idx = W'(i);
        end
    end
`endif

    // Load a fresh result on accept, drop valid on consume, otherwise hold under backpressure.
    always_comb begin
        out_valid_d = accept || (out_valid_q && !out_ready);
        out_idx_d   = accept ? enc_idx : out_idx_q;
        out_any_d   = accept ? enc_any : out_any_q;
    end

    // Output register; reset discards any held result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_any_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_any_q   <= out_any_d;
        end
    end
endmodule

// File: tb/tb_prio_enc_pipe.sv
// tb_prio_enc_pipe: randomized and directed checks of prio_enc_pipe against a transaction-level reference model.
module tb_prio_enc_pipe;
    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_idx;
    logic         out_any;

    int total = 0;
    int bad = 0;

    // Reference state: what the output register should hold, plus the rotation pointer.
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_idx = '0;
    logic         exp_any = 1'b0;
    int           mptr = N - 1;
    logic         exp_in_ready;
    logic         act_in_ready;

    prio_enc_pipe #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_any(out_any)
    );

    always #5 clk = ~clk;

    // Winner as {any, idx}: highest set bit, or in round-robin the first set bit counting down from p.
    function automatic logic [W:0] model_enc(input logic [N-1:0] r, input int p);
`ifdef PRIO_ENC_RR_EN
        for (int s = 0; s < N; s++) begin
            int j;
            j = (p - s + N) % N;
            if (r[j]) return {1'b1, W'(j)};
        end
`else
        for (int i = N - 1; i >= 0; i--) if (r[i]) return {1'b1, W'(i)};
`endif
        return '0;
    endfunction

    // Apply one cycle of inputs, update the model, and land #1 after the edge.
    task automatic advance(input logic v, input logic [N-1:0] r, input logic ordy);
        logic [W:0] res;
        in_valid = v;
        req = r;
        out_ready = ordy;
        #1;
        act_in_ready = in_ready;
        exp_in_ready = !exp_valid || ordy;
        if (v && exp_in_ready) begin
            res = model_enc(r, mptr);
            exp_valid = 1'b1;
            exp_any = res[W];
            exp_idx = res[W-1:0];
            if (exp_any) mptr = (exp_idx == '0) ? N - 1 : int'(exp_idx) - 1;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_idx = '0;
        exp_any = 1'b0;
        mptr = N - 1;
    endtask

    task automatic test_reset();
        #12;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        if (out_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
        if (out_any !== 1'b0) begin bad++; $display("FAIL reset_any got=%b want=0", out_any); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_fixed();
        logic [N-1:0] vecs [5] = '{8'h00, 8'h01, 8'h0A, 8'h80, 8'hFF};
        for (int k = 0; k < 5; k++) begin
            advance(1'b1, vecs[k], 1'b1);
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL fixed_valid[%0d] got=%b want=1", k, out_valid); end
            if (out_any !== exp_any) begin bad++; $display("FAIL fixed_any[%0d] got=%b want=%b", k, out_any, exp_any); end
            if (out_idx !== exp_idx) begin bad++; $display("FAIL fixed_idx[%0d] got=%0d want=%0d", k, out_idx, exp_idx); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        advance(1'b1, 8'h24, 1'b0);
        held = exp_idx;
        total++;
        if (out_idx !== held || out_valid !== 1'b1) begin bad++; $display("FAIL bp_load got=%0d/%b want=%0d/1", out_idx, out_valid, held); end
        for (int k = 0; k < 3; k++) begin
            advance(1'b1, 8'h01, 1'b0);
            total += 3;
            if (act_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", k, act_in_ready); end
            if (out_idx !== held) begin bad++; $display("FAIL bp_hold_idx[%0d] got=%0d want=%0d", k, out_idx, held); end
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", k, out_valid); end
        end
        advance(1'b1, 8'h01, 1'b1);
        total += 3;
        if (act_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", act_in_ready); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%b want=1", out_valid); end
        if (out_idx !== exp_idx) begin bad++; $display("FAIL bp_release_idx got=%0d want=%0d", out_idx, exp_idx); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] vecs [4] = '{8'h10, 8'h02, 8'h40, 8'h03};
        for (int k = 0; k < 4; k++) begin
            advance(1'b1, vecs[k], 1'b1);
            total += 3;
            if (act_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", k, act_in_ready); end
            if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", k, out_valid); end
            if (out_idx !== exp_idx) begin bad++; $display("FAIL b2b_idx[%0d] got=%0d want=%0d", k, out_idx, exp_idx); end
        end
        advance(1'b0, '0, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_mid_reset();
        advance(1'b1, 8'h5C, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
        if (out_idx !== '0) begin bad++; $display("FAIL midrst_idx got=%0d want=0", out_idx); end
        if (out_any !== 1'b0) begin bad++; $display("FAIL midrst_any got=%b want=0", out_any); end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    endtask

`ifdef PRIO_ENC_RR_EN
    task automatic test_round_robin();
        logic [N-1:0] vecs [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h09, 8'h09, 8'h06};
        for (int k = 0; k < 8; k++) begin
            advance(1'b1, vecs[k], 1'b1);
            total += 2;
            if (out_any !== exp_any) begin bad++; $display("FAIL rr_any[%0d] got=%b want=%b", k, out_any, exp_any); end
            if (out_idx !== exp_idx) begin bad++; $display("FAIL rr_idx[%0d] got=%0d want=%0d", k, out_idx, exp_idx); end
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            advance(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0));
            total += 2;
            if (act_in_ready !== exp_in_ready) begin bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", k, act_in_ready, exp_in_ready); end
            if (out_valid !== exp_valid) begin bad++; $display("FAIL rand_valid[%0d] got=%b want=%b", k, out_valid, exp_valid); end
            if (exp_valid) begin
                total += 2;
                if (out_any !== exp_any) begin bad++; $display("FAIL rand_any[%0d] got=%b want=%b", k, out_any, exp_any); end
                if (out_idx !== exp_idx) begin bad++; $display("FAIL rand_idx[%0d] got=%0d want=%0d", k, out_idx, exp_idx); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef PRIO_ENC_RR_EN
        test_round_robin();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
